// File: rtl/swipt_pkg.sv
// swipt_pkg -- shared definitions for the SWIPT FSK transmitter.
//   swipt_state_e   : frame sequencer states
//   DEF_F_*         : default carrier frequency words (idle / mark / space)
//   FRAME_CORE_BITS : start + 8 data + parity + stop bits of every frame
//   frame_bits()    : total frame length in bits for a given preamble length
//   even_parity8()  : parity bit that makes the 8 data bits plus parity even
package swipt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_START    = 3'd2,
        ST_DATA     = 3'd3,
        ST_PARITY   = 3'd4,
        ST_STOP     = 3'd5
    } swipt_state_e;

    localparam logic [31:0] DEF_F_IDLE  = 32'h0000_9470;
    localparam logic [31:0] DEF_F_MARK  = 32'h0000_9C40;
    localparam logic [31:0] DEF_F_SPACE = 32'h0000_8CA0;

    localparam int unsigned FRAME_CORE_BITS = 32'd11;

    function automatic int unsigned frame_bits(input int unsigned preamble_bits);
        return FRAME_CORE_BITS + preamble_bits;
    endfunction

    function automatic logic even_parity8(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/swipt_bit_timer.sv
// swipt_bit_timer -- down-counting bit timer.
//   clk  : rising-edge clock
//   nrst : synchronous active-high reset (clears counter and tick)
//   load : start a new bit; counter is loaded with len
//   len  : bit length minus one, in clk cycles
//   tick : registered, high while the counter sits at zero (last cycle of a bit)
module swipt_bit_timer
    import swipt_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        load,
    input  logic [15:0] len,
    output logic        tick
);

    logic [15:0] count_r;
    logic        tick_r;

    // Count down from len; tick is precomputed so it is valid while count_r is zero.
    always_ff @(posedge clk) begin
        if (nrst) begin
            count_r <= 16'd0;
            tick_r  <= 1'b0;
        end else if (load) begin
            count_r <= len;
            tick_r  <= (len == 16'd0);
        end else if (count_r != 16'd0) begin
            count_r <= count_r - 16'd1;
            tick_r  <= (count_r == 16'd1);
        end else begin
            tick_r  <= 1'b1;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/swipt_fsk_tx.sv
// swipt_fsk_tx -- FSK byte transmitter riding on a SWIPT power carrier.
// A byte is framed as: preamble (alternating, starting with 1), start bit 0,
// 8 data bits LSB first, even parity bit, stop bit 1. Each bit is sent as a
// frequency word (F_MARK for 1, F_SPACE for 0) held for BIT_CYCLES clocks.
//   clk        : rising-edge clock
//   nrst       : synchronous active-high reset
//   swiptAlive : link powered; losing it aborts any frame in flight
//   tx_valid   : byte offered
//   tx_data    : payload byte
//   tx_ready   : byte can be accepted this cycle
//   freq       : frequency word to the output stage
//   freq_rdy   : one-cycle pulse whenever freq changes
//   tx_busy    : frame in progress
//   tx_done    : one-cycle pulse when the stop bit completes
//   tx_abort   : one-cycle pulse when a frame is killed by swiptAlive falling
module swipt_fsk_tx
    import swipt_pkg::*;
#(
    parameter logic [31:0] F_IDLE        = DEF_F_IDLE,
    parameter logic [31:0] F_MARK        = DEF_F_MARK,
    parameter logic [31:0] F_SPACE       = DEF_F_SPACE,
    parameter int unsigned BIT_CYCLES    = 32'd25000,
    parameter int unsigned PREAMBLE_BITS = 32'd4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        swiptAlive,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic [31:0] freq,
    output logic        freq_rdy,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_abort
);

    localparam logic [15:0]  BIT_LEN     = 16'(BIT_CYCLES - 32'd1);
    localparam logic [3:0]   PRE_LAST    = (PREAMBLE_BITS == 32'd0) ? 4'd0
                                                                    : 4'(PREAMBLE_BITS - 32'd1);
    localparam swipt_state_e FIRST_STATE = (PREAMBLE_BITS == 32'd0) ? ST_START : ST_PREAMBLE;
    localparam logic [31:0]  FIRST_FREQ  = (PREAMBLE_BITS == 32'd0) ? F_SPACE : F_MARK;

    swipt_state_e state_r;
    logic [31:0]  freq_r;
    logic         freq_rdy_r;
    logic         tx_busy_r;
    logic         tx_done_r;
    logic         tx_abort_r;
    logic [7:0]   shift_r;
    logic [3:0]   bit_cnt_r;
    logic         parity_r;

    logic         tx_ready_s;
    logic         accept_s;
    logic         abort_s;
    logic         advance_s;
    logic         load_s;
    logic         tick_s;
    swipt_state_e nxt_state_s;
    logic         nxt_bit_s;
    logic [7:0]   nxt_shift_s;
    logic [3:0]   nxt_cnt_s;
    logic [31:0]  nxt_freq_s;

    function automatic logic [31:0] bit_freq(input logic b);
        if (b) begin
            return F_MARK;
        end else begin
            return F_SPACE;
        end
    endfunction

    // Handshake and timer control. tx_ready is held low while reset is applied.
    always_comb begin
        tx_ready_s = (state_r == ST_IDLE) & swiptAlive & ~nrst;
        accept_s   = tx_ready_s & tx_valid;
        abort_s    = (state_r != ST_IDLE) & ~swiptAlive;
        advance_s  = (state_r != ST_IDLE) & swiptAlive & tick_s;
        load_s     = accept_s | (advance_s & (state_r != ST_STOP));
    end

    // Which bit follows the current one when the bit timer expires.
    always_comb begin
        nxt_state_s = state_r;
        nxt_bit_s   = 1'b1;
        nxt_shift_s = shift_r;
        nxt_cnt_s   = bit_cnt_r;
        case (state_r)
            ST_PREAMBLE: begin
                if (bit_cnt_r == PRE_LAST) begin
                    nxt_state_s = ST_START;
                    nxt_bit_s   = 1'b0;
                    nxt_cnt_s   = 4'd0;
                end else begin
                    // preamble bit k is 1 for even k, so bit k+1 equals k's LSB
                    nxt_bit_s   = bit_cnt_r[0];
                    nxt_cnt_s   = bit_cnt_r + 4'd1;
                end
            end
            ST_START: begin
                nxt_state_s = ST_DATA;
                nxt_bit_s   = shift_r[0];
                nxt_cnt_s   = 4'd0;
            end
            ST_DATA: begin
                nxt_shift_s = {1'b0, shift_r[7:1]};
                nxt_cnt_s   = bit_cnt_r + 4'd1;
                if (bit_cnt_r == 4'd7) begin
                    nxt_state_s = ST_PARITY;
                    nxt_bit_s   = parity_r;
                end else begin
                    nxt_state_s = ST_DATA;
                    nxt_bit_s   = shift_r[1];
                end
            end
            ST_PARITY: begin
                nxt_state_s = ST_STOP;
                nxt_bit_s   = 1'b1;
            end
            ST_STOP: begin
                nxt_state_s = ST_IDLE;
                nxt_bit_s   = 1'b1;
            end
            default: begin
                nxt_state_s = ST_IDLE;
                nxt_bit_s   = 1'b1;
            end
        endcase
        if (nxt_state_s == ST_IDLE) begin
            nxt_freq_s = F_IDLE;
        end else begin
            nxt_freq_s = bit_freq(nxt_bit_s);
        end
    end

    // Frame sequencer with registered outputs; abort outranks a finishing stop bit.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_r    <= ST_IDLE;
            freq_r     <= F_IDLE;
            freq_rdy_r <= 1'b0;
            tx_busy_r  <= 1'b0;
            tx_done_r  <= 1'b0;
            tx_abort_r <= 1'b0;
            shift_r    <= 8'd0;
            bit_cnt_r  <= 4'd0;
            parity_r   <= 1'b0;
        end else if (abort_s) begin
            state_r    <= ST_IDLE;
            freq_r     <= F_IDLE;
            freq_rdy_r <= (freq_r != F_IDLE);
            tx_busy_r  <= 1'b0;
            tx_done_r  <= 1'b0;
            tx_abort_r <= 1'b1;
            shift_r    <= 8'd0;
            bit_cnt_r  <= 4'd0;
            parity_r   <= 1'b0;
        end else if (accept_s) begin
            state_r    <= FIRST_STATE;
            freq_r     <= FIRST_FREQ;
            freq_rdy_r <= (freq_r != FIRST_FREQ);
            tx_busy_r  <= 1'b1;
            tx_done_r  <= 1'b0;
            tx_abort_r <= 1'b0;
            shift_r    <= tx_data;
            bit_cnt_r  <= 4'd0;
            parity_r   <= even_parity8(tx_data);
        end else if (advance_s) begin
            state_r    <= nxt_state_s;
            freq_r     <= nxt_freq_s;
            freq_rdy_r <= (nxt_freq_s != freq_r);
            tx_busy_r  <= (nxt_state_s != ST_IDLE);
            tx_done_r  <= (state_r == ST_STOP);
            tx_abort_r <= 1'b0;
            shift_r    <= nxt_shift_s;
            bit_cnt_r  <= nxt_cnt_s;
        end else begin
            freq_rdy_r <= 1'b0;
            tx_done_r  <= 1'b0;
            tx_abort_r <= 1'b0;
        end
    end

    swipt_bit_timer u_bit_timer (
        .clk  (clk),
        .nrst (nrst),
        .load (load_s),
        .len  (BIT_LEN),
        .tick (tick_s)
    );

    assign tx_ready = tx_ready_s;
    assign freq     = freq_r;
    assign freq_rdy = freq_rdy_r;
    assign tx_busy  = tx_busy_r;
    assign tx_done  = tx_done_r;
    assign tx_abort = tx_abort_r;

endmodule

// File: tb/tb_swipt_fsk_tx.sv
// tb_swipt_fsk_tx -- self-checking bench for swipt_fsk_tx.
// Two instances: A (BIT_CYCLES=16, PREAMBLE_BITS=2) and B (BIT_CYCLES=2,
// PREAMBLE_BITS=2). A frame-level reference model expands a byte into the
// expected per-clock frequency words; every frame clock is compared.
module tb_swipt_fsk_tx;

    localparam logic [31:0] FI   = 32'h0000_9470;
    localparam logic [31:0] FM   = 32'h0000_9C40;
    localparam logic [31:0] FS   = 32'h0000_8CA0;
    localparam int          PRE  = 2;
    localparam int          BC_A = 16;
    localparam int          BC_B = 2;

    logic        clk = 1'b0;
    logic        nrst;
    logic        swiptAlive;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        sel;

    logic        tx_valid_a, tx_ready_a, freq_rdy_a, tx_busy_a, tx_done_a, tx_abort_a;
    logic        tx_valid_b, tx_ready_b, freq_rdy_b, tx_busy_b, tx_done_b, tx_abort_b;
    logic [31:0] freq_a, freq_b;

    logic        tx_ready_m, freq_rdy_m, tx_busy_m, tx_done_m, tx_abort_m;
    logic [31:0] freq_m;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [7:0] d;
        logic       par;
        int         pulses;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;

    assign tx_valid_a = tx_valid & ~sel;
    assign tx_valid_b = tx_valid & sel;
    assign freq_m     = sel ? freq_b     : freq_a;
    assign freq_rdy_m = sel ? freq_rdy_b : freq_rdy_a;
    assign tx_busy_m  = sel ? tx_busy_b  : tx_busy_a;
    assign tx_done_m  = sel ? tx_done_b  : tx_done_a;
    assign tx_abort_m = sel ? tx_abort_b : tx_abort_a;
    assign tx_ready_m = sel ? tx_ready_b : tx_ready_a;

    swipt_fsk_tx #(
        .BIT_CYCLES    (BC_A),
        .PREAMBLE_BITS (PRE)
    ) dut_a (
        .clk        (clk),
        .nrst       (nrst),
        .swiptAlive (swiptAlive),
        .tx_valid   (tx_valid_a),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready_a),
        .freq       (freq_a),
        .freq_rdy   (freq_rdy_a),
        .tx_busy    (tx_busy_a),
        .tx_done    (tx_done_a),
        .tx_abort   (tx_abort_a)
    );

    swipt_fsk_tx #(
        .BIT_CYCLES    (BC_B),
        .PREAMBLE_BITS (PRE)
    ) dut_b (
        .clk        (clk),
        .nrst       (nrst),
        .swiptAlive (swiptAlive),
        .tx_valid   (tx_valid_b),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready_b),
        .freq       (freq_b),
        .freq_rdy   (freq_rdy_b),
        .tx_busy    (tx_busy_b),
        .tx_done    (tx_done_b),
        .tx_abort   (tx_abort_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_bit(input bit b, input int bc);
        for (int k = 0; k < bc; k++) exp_q.push_back(b ? FM : FS);
    endtask

    // Reference model: expand a byte into the frequency word of every frame clock.
    task automatic build_exp(input logic [7:0] d, input int bc);
        int ones;
        ones = 0;
        exp_q.delete();
        for (int i = 0; i < PRE; i++) push_bit((i % 2) == 0, bc);
        push_bit(1'b0, bc);
        for (int i = 0; i < 8; i++) begin
            push_bit(((d >> i) & 8'd1) != 8'd0, bc);
            ones += int'((d >> i) & 8'd1);
        end
        push_bit((ones % 2) == 1, bc);
        push_bit(1'b1, bc);
    endtask

    // Offer a byte at the current negedge and compare every clock of its frame.
    // stop_at >= 0 returns right after that frame clock has been checked.
    task automatic send(input logic [7:0] d, input bit hold, input logic [7:0] next_d,
                        input int stop_at, output int pulses, output logic [31:0] par_freq,
                        output int busy_cnt);
        int          bc;
        int          n;
        logic [31:0] prev;
        logic [31:0] e;
        bc       = sel ? BC_B : BC_A;
        n        = 0;
        prev     = FI;
        pulses   = 0;
        busy_cnt = 0;
        par_freq = 32'd0;
        build_exp(d, bc);
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready_m !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 64'(tx_ready_m), 64'(1'b1));
        if (tx_ready_m !== 1'b1) begin
            tx_valid = 1'b0;
            return;
        end
        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge clk);
            if (j == 0 && !hold) tx_valid = 1'b0;
            e = exp_q[j];
            pulses   += int'(freq_rdy_m);
            busy_cnt += int'(tx_busy_m);
            if (j == (PRE + 9) * bc + bc / 2) par_freq = freq_m;
            check("frame_cycle",
                  64'({freq_m, freq_rdy_m, tx_busy_m, tx_done_m, tx_abort_m, tx_ready_m}),
                  64'({e, (e != prev), 1'b1, 1'b0, 1'b0, 1'b0}));
            prev = e;
            if (j == exp_q.size() - 1) tx_data = next_d;
            if (j == stop_at) return;
        end
        @(negedge clk);
        pulses += int'(freq_rdy_m);
        check("stop_return",
              64'({freq_m, freq_rdy_m, tx_busy_m, tx_done_m, tx_abort_m, tx_ready_m}),
              64'({FI, 1'b1, 1'b0, 1'b1, 1'b0, swiptAlive}));
        if (!hold) begin
            @(negedge clk);
            check("idle_after",
                  64'({freq_m, freq_rdy_m, tx_busy_m, tx_done_m, tx_abort_m}),
                  64'({FI, 1'b0, 1'b0, 1'b0, 1'b0}));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          p;
        int          bcnt;
        logic [31:0] pf;
        logic [7:0]  d;

        tbl[0] = '{8'hA5, 1'b0, 12};
        tbl[1] = '{8'h00, 1'b0, 4};
        tbl[2] = '{8'hFF, 1'b0, 6};
        tbl[3] = '{8'h01, 1'b1, 6};
        tbl[4] = '{8'h80, 1'b1, 4};

        nrst       = 1'b1;
        swiptAlive = 1'b1;
        tx_valid   = 1'b0;
        tx_data    = 8'd0;
        sel        = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_a", 64'({freq_a, freq_rdy_a, tx_busy_a, tx_done_a, tx_abort_a, tx_ready_a}),
              64'({FI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        check("reset_b", 64'({freq_b, freq_rdy_b, tx_busy_b, tx_done_b, tx_abort_b, tx_ready_b}),
              64'({FI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        nrst = 1'b0;
        #1;
        check("ready_after_reset", 64'(tx_ready_a), 64'(1'b1));

        // Table of known frames: parity bit and freq_rdy pulse count.
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].d, 1'b0, 8'd0, -1, p, pf, bcnt);
            check("tbl_pulses", 64'(p), 64'(tbl[i].pulses));
            check("tbl_parity", 64'(pf), 64'(tbl[i].par ? FM : FS));
        end

        // Back-to-back with tx_valid held: one idle clock between frames.
        send(8'h00, 1'b1, 8'hFF, -1, p, pf, bcnt);
        check("b2b_par0", 64'(pf), 64'(FS));
        check("b2b_pulses0", 64'(p), 64'(4));
        send(8'hFF, 1'b0, 8'd0, -1, p, pf, bcnt);
        check("b2b_par1", 64'(pf), 64'(FS));

        // swiptAlive drops during data bit 3.
        send(8'h3C, 1'b0, 8'd0, (PRE + 1 + 3) * BC_A + 5, p, pf, bcnt);
        swiptAlive = 1'b0;
        tx_valid   = 1'b1;
        tx_data    = 8'h77;
        @(negedge clk);
        check("abort_edge", 64'({freq_a, freq_rdy_a, tx_busy_a, tx_done_a, tx_abort_a, tx_ready_a}),
              64'({FI, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("abort_hold", 64'({freq_a, freq_rdy_a, tx_busy_a, tx_done_a, tx_abort_a, tx_ready_a}),
                  64'({FI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        end
        swiptAlive = 1'b1;
        #1;
        check("ready_alive_back", 64'(tx_ready_a), 64'(1'b1));
        tx_valid = 1'b0;
        @(negedge clk);
        check("idle_no_accept", 64'({freq_a, tx_busy_a}), 64'({FI, 1'b0}));

        // Reset held 3 clocks mid-data, then a clean frame.
        send(8'hC3, 1'b0, 8'd0, (PRE + 1 + 2) * BC_A + 3, p, pf, bcnt);
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_reset", 64'({freq_a, freq_rdy_a, tx_busy_a, tx_done_a, tx_abort_a, tx_ready_a}),
                  64'({FI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        end
        nrst = 1'b0;
        #1;
        check("ready_after_mid_reset", 64'(tx_ready_a), 64'(1'b1));
        send(8'h5A, 1'b0, 8'd0, -1, p, pf, bcnt);

        // Random bytes with random idle gaps.
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(d, 1'b0, 8'd0, -1, p, pf, bcnt);
            check("rand_busy_len", 64'(bcnt), 64'(13 * BC_A));
        end

        // Two-clock bits: 26-clock frames.
        sel = 1'b1;
        send(8'hA5, 1'b0, 8'd0, -1, p, pf, bcnt);
        check("b_frame_len", 64'(bcnt), 64'(26));
        check("b_pulses", 64'(p), 64'(12));
        send(8'h81, 1'b0, 8'd0, -1, p, pf, bcnt);
        check("b_frame_len2", 64'(bcnt), 64'(26));
        check("b_parity", 64'(pf), 64'(FS));
        sel = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
